buzzer_alert_scheduler: RTL and testbench

BUZZER_ALERT_SCHEDULER -- requirements
Module: buzzer_alert_scheduler

---
 rtl/obstacle_pkg.sv | 33 +++
 rtl/sensor_debounce.sv | 42 ++++
 rtl/buzzer_alert_scheduler.sv | 135 +++++++++++++
 tb/tb_buzzer_alert_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and default timing for the obstacle buzzer scheduler.
// Holds the FSM state encoding, the side enum and the arbitration helpers.
package obstacle_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEEP = 2'd1,
      GAP  = 2'd2
   } state_e;

   typedef enum logic {
      SIDE_L = 1'b0,
      SIDE_R = 1'b1
   } side_e;

   localparam logic [15:0] DEF_DEB_CYCLES     = 16'd50000;
   localparam logic [23:0] DEF_ON_CYCLES      = 24'd2500000;
   localparam logic [23:0] DEF_OFF_CYCLES     = 24'd5000000;
   localparam logic [23:0] DEF_OFF_URG_CYCLES = 24'd1250000;
   localparam logic [27:0] DEF_URG_CYCLES     = 28'd50000000;

   // A lone detection wins outright; a tie goes to whoever was not served last.
   function automatic side_e pickSide(input logic detL, input logic detR, input side_e lastServed);
      if (detL && !detR) return SIDE_L;
      if (detR && !detL) return SIDE_R;
      return (lastServed == SIDE_L) ? SIDE_R : SIDE_L;
   endfunction

   function automatic logic [1:0] buzzFor(input side_e who, input side_e active, input logic urg);
      return (who == active) ? {urg, 1'b1} : 2'b00;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw sensor.
// The debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
module sensor_debounce
   import obstacle_pkg::*;
#(
   parameter logic [15:0] DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic sensor_i,
   output logic det_o
);

   logic        sync1_q;
   logic        sync2_q;
   logic        det_q;
   logic [15:0] cnt_q;

   // Any agreeing sample reloads the countdown, so a glitch restarts the wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         det_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         sync1_q <= sensor_i;
         sync2_q <= sync1_q;
         if (sync2_q == det_q) begin
            cnt_q <= DEB_CYCLES - 16'd1;
         end else if (cnt_q == 16'd0) begin
            det_q <= sync2_q;
            cnt_q <= DEB_CYCLES - 16'd1;
         end else begin
            cnt_q <= cnt_q - 16'd1;
         end
      end
   end

   assign det_o = det_q;

endmodule

// File: rtl/buzzer_alert_scheduler.sv
// Time-shares one buzzer between left and right obstacle sensors with beep/gap
// bursts, fair tie-breaking and a shorter gap once a side has been urgent.
module buzzer_alert_scheduler
   import obstacle_pkg::*;
#(
   parameter logic [15:0] DEB_CYCLES     = DEF_DEB_CYCLES,
   parameter logic [23:0] ON_CYCLES      = DEF_ON_CYCLES,
   parameter logic [23:0] OFF_CYCLES     = DEF_OFF_CYCLES,
   parameter logic [23:0] OFF_URG_CYCLES = DEF_OFF_URG_CYCLES,
   parameter logic [27:0] URG_CYCLES     = DEF_URG_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor_left,
   input  logic       sensor_right,
   output logic [1:0] left_buzz,
   output logic [1:0] right_buzz,
   output logic       busy
);

   logic        detL, detR;
   logic [27:0] persL_q, persL_d, persR_q, persR_d;
   logic        urgL, urgR, urgNextL, urgNextR;
   logic        anyDet, grantDet, grantUrg, grantUrgNext, pickUrgNext;
   side_e       pick;
   logic [23:0] gapLoad;

   state_e      state_q;
   side_e       grant_q, lastServed_q;
   logic [23:0] timer_q;
   logic [1:0]  leftBuzz_q, rightBuzz_q;
   logic        busy_q;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebL (
      .clk(clk), .rst(rst), .sensor_i(sensor_left), .det_o(detL)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebR (
      .clk(clk), .rst(rst), .sensor_i(sensor_right), .det_o(detR)
   );

   // Registered buzz bits use the next urgency so bit1 tracks urg in the same cycle.
   always_comb begin
      persL_d = 28'd0;
      persR_d = 28'd0;
      if (detL) persL_d = (persL_q == URG_CYCLES) ? persL_q : persL_q + 28'd1;
      if (detR) persR_d = (persR_q == URG_CYCLES) ? persR_q : persR_q + 28'd1;
      urgL         = (persL_q == URG_CYCLES);
      urgR         = (persR_q == URG_CYCLES);
      urgNextL     = (persL_d == URG_CYCLES);
      urgNextR     = (persR_d == URG_CYCLES);
      anyDet       = detL | detR;
      pick         = pickSide(detL, detR, lastServed_q);
      pickUrgNext  = (pick == SIDE_L) ? urgNextL : urgNextR;
      grantDet     = (grant_q == SIDE_L) ? detL : detR;
      grantUrg     = (grant_q == SIDE_L) ? urgL : urgR;
      grantUrgNext = (grant_q == SIDE_L) ? urgNextL : urgNextR;
      gapLoad      = grantUrg ? (OFF_URG_CYCLES - 24'd1) : (OFF_CYCLES - 24'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         persL_q <= 28'd0;
         persR_q <= 28'd0;
      end else begin
         persL_q <= persL_d;
         persR_q <= persR_d;
      end
   end

   // GAP end re-arbitrates directly so a held sensor never passes through IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= SIDE_L;
         lastServed_q <= SIDE_R;
         timer_q      <= 24'd0;
         leftBuzz_q   <= 2'b00;
         rightBuzz_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (anyDet) begin
                  state_q     <= BEEP;
                  grant_q     <= pick;
                  timer_q     <= ON_CYCLES - 24'd1;
                  leftBuzz_q  <= buzzFor(SIDE_L, pick, pickUrgNext);
                  rightBuzz_q <= buzzFor(SIDE_R, pick, pickUrgNext);
                  busy_q      <= 1'b1;
               end
            end
            BEEP: begin
               if (!grantDet || timer_q == 24'd0) begin
                  state_q      <= GAP;
                  lastServed_q <= grant_q;
                  timer_q      <= gapLoad;
                  leftBuzz_q   <= 2'b00;
                  rightBuzz_q  <= 2'b00;
               end else begin
                  timer_q     <= timer_q - 24'd1;
                  leftBuzz_q  <= buzzFor(SIDE_L, grant_q, grantUrgNext);
                  rightBuzz_q <= buzzFor(SIDE_R, grant_q, grantUrgNext);
               end
            end
            GAP: begin
               if (timer_q != 24'd0) begin
                  timer_q <= timer_q - 24'd1;
               end else if (anyDet) begin
                  state_q     <= BEEP;
                  grant_q     <= pick;
                  timer_q     <= ON_CYCLES - 24'd1;
                  leftBuzz_q  <= buzzFor(SIDE_L, pick, pickUrgNext);
                  rightBuzz_q <= buzzFor(SIDE_R, pick, pickUrgNext);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               timer_q     <= 24'd0;
               leftBuzz_q  <= 2'b00;
               rightBuzz_q <= 2'b00;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign left_buzz  = leftBuzz_q;
   assign right_buzz = rightBuzz_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_buzzer_alert_scheduler.sv
// Bench for buzzer_alert_scheduler: directed scenarios with absolute cycle
// expectations plus a random phase checked against a behavioural model.
module tb_buzzer_alert_scheduler;

   localparam int DEB  = 4;
   localparam int ON   = 8;
   localparam int OFF  = 8;
   localparam int OFFU = 4;
   localparam int URG  = 32;

   localparam int PH_IDLE = 0;
   localparam int PH_BEEP = 1;
   localparam int PH_GAP  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       sensor_left, sensor_right;
   logic [1:0] left_buzz, right_buzz;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int mSync1[2], mSync2[2], mDet[2], mRun[2], mPersist[2];
   int mPhase, mSide, mLast, mElapsed, mGapLen;
   logic [1:0] expLeft, expRight;
   logic       expBusy;

   always #5 clk = ~clk;

   buzzer_alert_scheduler #(
      .DEB_CYCLES    (16'(DEB)),
      .ON_CYCLES     (24'(ON)),
      .OFF_CYCLES    (24'(OFF)),
      .OFF_URG_CYCLES(24'(OFFU)),
      .URG_CYCLES    (28'(URG))
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sensor_left (sensor_left),
      .sensor_right(sensor_right),
      .left_buzz   (left_buzz),
      .right_buzz  (right_buzz),
      .busy        (busy)
   );

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int chooseSide(input int dl, input int dr, input int last);
      if (dl != 0 && dr == 0) return 0;
      if (dr != 0 && dl == 0) return 1;
      return 1 - last;
   endfunction

   task automatic modelReset();
      for (int s = 0; s < 2; s++) begin
         mSync1[s] = 0; mSync2[s] = 0; mDet[s] = 0; mRun[s] = 0; mPersist[s] = 0;
      end
      mPhase = PH_IDLE; mSide = 0; mLast = 1; mElapsed = 0; mGapLen = OFF;
      expLeft = 2'b00; expRight = 2'b00; expBusy = 1'b0;
   endtask

   // Advances the model by one clock: scheduler decisions use the levels seen
   // during the current cycle, then the sensor pipeline moves on.
   task automatic modelStep(input int rawL, input int rawR);
      int  det0[2];
      int  urgNow[2];
      int  raw[2];
      logic u;
      raw[0] = rawL; raw[1] = rawR;
      for (int s = 0; s < 2; s++) begin
         det0[s]   = mDet[s];
         urgNow[s] = (mPersist[s] == URG) ? 1 : 0;
      end
      case (mPhase)
         PH_IDLE: if (det0[0] != 0 || det0[1] != 0) begin
            mSide = chooseSide(det0[0], det0[1], mLast); mPhase = PH_BEEP; mElapsed = 1;
         end
         PH_BEEP: if (det0[mSide] == 0 || mElapsed == ON) begin
            mGapLen = (urgNow[mSide] != 0) ? OFFU : OFF;
            mLast = mSide; mPhase = PH_GAP; mElapsed = 1;
         end else mElapsed++;
         default: if (mElapsed == mGapLen) begin
            if (det0[0] != 0 || det0[1] != 0) begin
               mSide = chooseSide(det0[0], det0[1], mLast); mPhase = PH_BEEP; mElapsed = 1;
            end else mPhase = PH_IDLE;
         end else mElapsed++;
      endcase
      for (int s = 0; s < 2; s++) begin
         mPersist[s] = (det0[s] != 0) ? ((mPersist[s] + 1 > URG) ? URG : mPersist[s] + 1) : 0;
         if (mSync2[s] != mDet[s]) begin
            mRun[s]++;
            if (mRun[s] == DEB) begin mDet[s] = mSync2[s]; mRun[s] = 0; end
         end else mRun[s] = 0;
         mSync2[s] = mSync1[s];
         mSync1[s] = raw[s];
      end
      u = (mPersist[mSide] == URG);
      expLeft  = (mPhase == PH_BEEP && mSide == 0) ? {u, 1'b1} : 2'b00;
      expRight = (mPhase == PH_BEEP && mSide == 1) ? {u, 1'b1} : 2'b00;
      expBusy  = (mPhase != PH_IDLE);
   endtask

   // Drives one cycle of sensor levels and compares the resulting outputs.
   task automatic applyStimulus(input logic l, input logic r);
      sensor_left  = l;
      sensor_right = r;
      modelStep(int'(l), int'(r));
      @(negedge clk);
      checkOutput("model_left", {2'b00, left_buzz}, {2'b00, expLeft});
      checkOutput("model_right", {2'b00, right_buzz}, {2'b00, expRight});
      checkOutput("model_busy", {3'b000, busy}, {3'b000, expBusy});
      checkOutput("one_tone", {3'b000, left_buzz[0] & right_buzz[0]}, 4'h0);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      sensor_left = 1'b0;
      sensor_right = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("rst_left", {2'b00, left_buzz}, 4'h0);
      checkOutput("rst_right", {2'b00, right_buzz}, 4'h0);
      checkOutput("rst_busy", {3'b000, busy}, 4'h0);
      rst = 1'b0;
   endtask

   initial begin
      int holdL, holdR;
      logic rawL, rawR;
      rst = 1'b1;
      sensor_left = 1'b0;
      sensor_right = 1'b0;
      $display("[TB] buzzer_alert_scheduler bench starting");

      // Single held left sensor: burst, full gap, burst again.
      resetDut();
      for (int k = 1; k <= 24; k++) begin
         applyStimulus(1'b1, 1'b0);
         if (k == 7 || k == 14 || k == 23) checkOutput("s1_burst", {2'b00, left_buzz}, 4'h1);
         if (k == 6 || k == 15 || k == 22) checkOutput("s1_quiet", {2'b00, left_buzz}, 4'h0);
      end

      // Simultaneous rise: left first, then right.
      resetDut();
      for (int k = 1; k <= 31; k++) begin
         applyStimulus(1'b1, 1'b1);
         if (k == 7) begin
            checkOutput("s2_left_first", {2'b00, left_buzz}, 4'h1);
            checkOutput("s2_right_wait", {2'b00, right_buzz}, 4'h0);
         end
         if (k == 23 || k == 30) begin
            checkOutput("s2_right_turn", {2'b00, right_buzz}, 4'h1);
            checkOutput("s2_left_wait", {2'b00, left_buzz}, 4'h0);
         end
      end

      // Short glitch on the right never debounces.
      resetDut();
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(1'b0, k <= 3);
         checkOutput("s3_right_silent", {2'b00, right_buzz}, 4'h0);
         checkOutput("s3_idle", {3'b000, busy}, 4'h0);
      end

      // Long hold: urgency appears and gaps shorten.
      resetDut();
      for (int k = 1; k <= 52; k++) begin
         applyStimulus(1'b1, 1'b0);
         if (k == 38 || k == 47 || k == 50) checkOutput("s4_gap", {2'b00, left_buzz}, 4'h0);
         if (k == 39 || k == 46 || k == 51) checkOutput("s4_urgent", {2'b00, left_buzz}, 4'h3);
      end

      // Left released mid-burst: abort, full gap, back to idle.
      resetDut();
      for (int k = 1; k <= 22; k++) begin
         applyStimulus(k <= 4, 1'b0);
         if (k == 10) checkOutput("s5_still_on", {2'b00, left_buzz}, 4'h1);
         if (k == 11) checkOutput("s5_aborted", {2'b00, left_buzz}, 4'h0);
         if (k == 11 || k == 18) checkOutput("s5_gap_busy", {3'b000, busy}, 4'h1);
         if (k == 19) checkOutput("s5_idle", {3'b000, busy}, 4'h0);
      end

      // Reset in the middle of a burst silences outputs immediately.
      resetDut();
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b1, 1'b1);
         if (k == 10) checkOutput("s6_beeping", {2'b00, left_buzz}, 4'h1);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("s6_async_left", {2'b00, left_buzz}, 4'h0);
      checkOutput("s6_async_right", {2'b00, right_buzz}, 4'h0);
      checkOutput("s6_async_busy", {3'b000, busy}, 4'h0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b1);
         if (k == 7) begin
            checkOutput("s6_left_again", {2'b00, left_buzz}, 4'h1);
            checkOutput("s6_right_wait", {2'b00, right_buzz}, 4'h0);
         end
      end

      // Random sensor activity mixing glitches, short holds and long holds.
      resetDut();
      holdL = 0; holdR = 0; rawL = 1'b0; rawR = 1'b0;
      for (int n = 0; n < 700; n++) begin
         if (holdL == 0) begin
            rawL  = 1'($urandom_range(1, 0));
            holdL = ($urandom_range(3, 0) == 0) ? int'($urandom_range(60, 20)) : int'($urandom_range(12, 1));
         end
         if (holdR == 0) begin
            rawR  = 1'($urandom_range(1, 0));
            holdR = ($urandom_range(3, 0) == 0) ? int'($urandom_range(60, 20)) : int'($urandom_range(12, 1));
         end
         holdL--;
         holdR--;
         applyStimulus(rawL, rawR);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
